// File: rtl/flags_register.sv
// Processor flags register: captures ALU flags, loads/drives them over the data bus,
// keeps a one-deep shadow copy for save/restore, and evaluates branch conditions.
module flags_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_zero,
    input  logic             flag_acarry,
    input  logic             flag_lcarry,
    input  logic             flag_sign,
    input  logic             flag_overflow,
    input  logic             capture,
    input  logic             load_bus,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             assert_bus,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_en,
    input  logic             save,
    input  logic             restore,
    input  logic [2:0]       cond_sel,
    output logic             cond_true,
    output logic             carry_out,
    output logic [4:0]       flags,
    output logic             shadow_valid,
    output logic             restore_err
);

    // Member order matches the bus image: overflow is bit 4, zero is bit 0.
    typedef struct packed {
        logic overflow;
        logic sign;
        logic lcarry;
        logic acarry;
        logic zero;
    } flags_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_S      = 3'd5,
        COND_V      = 3'd6,
        COND_L      = 3'd7
    } cond_e;

    flags_t flags_q,  flags_d;
    flags_t shadow_q, shadow_d;
    logic   valid_q,  valid_d;
    logic   err_q,    err_d;

    flags_t alu_flags;
    assign alu_flags = '{overflow: flag_overflow, sign: flag_sign, lcarry: flag_lcarry,
                         acarry: flag_acarry, zero: flag_zero};

    // Upper bus bits carry no flag information on a load.
    logic bus_in_unused;
    assign bus_in_unused = ^bus_in[WIDTH-1:5];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        flags_d  = flags_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        err_d    = err_q;

        if (load_bus) begin
            flags_d = bus_in[4:0];
        end else if (restore && valid_q) begin
            flags_d = shadow_q;
        end else if (capture) begin
            flags_d = alu_flags;
        end

        if (restore) begin
            if (valid_q) valid_d = 1'b0;
            else         err_d   = 1'b1;
        end

        // Save always snapshots the pre-edge value and wins over a concurrent restore's clear of V.
        if (save) begin
            shadow_d = flags_q;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
        if (reset) begin
            flags_q  <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flags_q.zero;
            COND_NZ:     cond_true = ~flags_q.zero;
            COND_C:      cond_true = flags_q.acarry;
            COND_NC:     cond_true = ~flags_q.acarry;
            COND_S:      cond_true = flags_q.sign;
            COND_V:      cond_true = flags_q.overflow;
            COND_L:      cond_true = flags_q.lcarry;
        endcase
    end

    assign bus_en       = assert_bus;
    assign bus_out      = assert_bus ? {{(WIDTH-5){1'b0}}, flags_q} : '0;
    assign carry_out    = flags_q.acarry;
    assign flags        = flags_q;
    assign shadow_valid = valid_q;
    assign restore_err  = err_q;

endmodule

// File: tb/tb_flags_register.sv
// Self-checking bench for flags_register: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the flag/shadow rules.
module tb_flags_register;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       alu;
    logic             capture, load_bus, assert_bus, save, restore;
    logic [WIDTH-1:0] bus_in;
    logic [2:0]       cond_sel;
    logic [WIDTH-1:0] bus_out;
    logic             bus_en, cond_true, carry_out, shadow_valid, restore_err;
    logic [4:0]       flags;

    always #5 clk = ~clk;

    flags_register #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flag_zero    (alu[0]),
        .flag_acarry  (alu[1]),
        .flag_lcarry  (alu[2]),
        .flag_sign    (alu[3]),
        .flag_overflow(alu[4]),
        .capture      (capture),
        .load_bus     (load_bus),
        .bus_in       (bus_in),
        .assert_bus   (assert_bus),
        .bus_out      (bus_out),
        .bus_en       (bus_en),
        .save         (save),
        .restore      (restore),
        .cond_sel     (cond_sel),
        .cond_true    (cond_true),
        .carry_out    (carry_out),
        .flags        (flags),
        .shadow_valid (shadow_valid),
        .restore_err  (restore_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: flag word, shadow word, shadow-valid, sticky error.
    logic [4:0] m_f, m_s;
    logic       m_v, m_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_cond(input logic [4:0] f, input logic [2:0] sel);
        logic [7:0] table_bits;
        // Indexed by cond_sel: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 V, 7 L.
        table_bits = {f[2], f[4], f[3], ~f[1], f[1], ~f[0], f[0], 1'b1};
        return table_bits[sel];
    endfunction

    task automatic model_edge();
        logic [4:0] old_f;
        logic       restoring;
        if (reset) begin
            m_f = '0; m_s = '0; m_v = 1'b0; m_e = 1'b0;
        end else begin
            old_f     = m_f;
            restoring = restore && m_v;
            m_f = load_bus ? bus_in[4:0] : restoring ? m_s : capture ? alu : old_f;
            if (restore && !m_v) m_e = 1'b1;
            if (restoring)       m_v = 1'b0;
            if (save) begin
                m_s = old_f;
                m_v = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":bus_en"},  32'(bus_en), 32'(assert_bus));
        check({tag, ":bus_out"}, 32'(bus_out), assert_bus ? 32'(m_f) : 32'd0);
        check({tag, ":flags"},   32'(flags), 32'(m_f));
        check({tag, ":cond"},    32'(cond_true), 32'(model_cond(m_f, cond_sel)));
        check({tag, ":carry"},   32'(carry_out), 32'(m_f[1]));
        check({tag, ":valid"},   32'(shadow_valid), 32'(m_v));
        check({tag, ":err"},     32'(restore_err), 32'(m_e));
    endtask

    // Check pre-edge outputs, clock one edge, advance the model, return at the falling edge.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; capture = 0; load_bus = 0; assert_bus = 0;
        save = 0; restore = 0; bus_in = '0; alu = '0; cond_sel = 3'd0;
    endtask

    initial begin
        idle();
        m_f = 'x; m_s = 'x; m_v = 1'bx; m_e = 1'bx;
        reset = 1;
        @(negedge clk);
        @(posedge clk); model_edge(); @(negedge clk);
        reset = 0;

        // Reset state
        #1;
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_valid", 32'(shadow_valid), 32'd0);
        check("rst_err",   32'(restore_err), 32'd0);
        check("rst_cond0", 32'(cond_true), 32'd1);
        cond_sel = 3'd2; #1;
        check("rst_cond2", 32'(cond_true), 32'd1);
        cond_sel = 3'd0;

        // Capture acarry only (200+64 overflows 8 bits)
        alu = 5'b00010; capture = 1;
        tick("cap");
        idle(); #1;
        check("cap_flags", 32'(flags), 32'h02);
        check("cap_carry", 32'(carry_out), 32'd1);
        cond_sel = 3'd3; #1; check("cap_c",  32'(cond_true), 32'd1);
        cond_sel = 3'd4; #1; check("cap_nc", 32'(cond_true), 32'd0);
        cond_sel = 3'd0;

        // Bus load of all-ones, then drive it back out
        load_bus = 1; bus_in = 8'hFF;
        tick("ld");
        idle(); #1;
        check("ld_flags", 32'(flags), 32'h1F);
        assert_bus = 1; #1;
        check("drv_bus", 32'(bus_out), 32'h1F);
        check("drv_en",  32'(bus_en), 32'd1);
        assert_bus = 0; #1;
        check("drv_off", 32'(bus_out), 32'd0);

        // Save concurrent with capture, then restore
        load_bus = 1; bus_in = 8'h01;
        tick("ld1");
        idle(); save = 1; capture = 1; alu = 5'b01000;
        tick("savecap");
        idle(); #1;
        check("sc_flags", 32'(flags), 32'h08);
        check("sc_valid", 32'(shadow_valid), 32'd1);
        restore = 1;
        tick("rest");
        idle(); #1;
        check("rs_flags", 32'(flags), 32'h01);
        check("rs_valid", 32'(shadow_valid), 32'd0);

        // Restore with an empty shadow is an error that sticks
        restore = 1;
        tick("bad_rest");
        idle(); #1;
        check("br_flags", 32'(flags), 32'h01);
        check("br_err",   32'(restore_err), 32'd1);
        for (int i = 0; i < 3; i++) tick("hold");
        #1; check("br_sticky", 32'(restore_err), 32'd1);

        // Load beats capture
        load_bus = 1; capture = 1; bus_in = 8'h10; alu = 5'b00111;
        tick("ldcap");
        idle(); #1;
        check("lc_flags", 32'(flags), 32'h10);

        // Drive and load together: bus shows old value, no bypass
        load_bus = 1; bus_in = 8'h04;
        tick("ld4");
        idle(); assert_bus = 1; load_bus = 1; bus_in = 8'h03; #1;
        check("nb_bus", 32'(bus_out), 32'h04);
        tick("nb");
        idle(); #1;
        check("nb_flags", 32'(flags), 32'h03);

        // Reset with save pending clears everything
        save = 1; reset = 1;
        tick("rstsave");
        idle(); #1;
        check("rs0_flags", 32'(flags), 32'd0);
        check("rs0_valid", 32'(shadow_valid), 32'd0);
        check("rs0_err",   32'(restore_err), 32'd0);
        restore = 1;
        tick("rs0_rest");
        idle(); #1;
        check("rs0_noshadow", 32'(restore_err), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            load_bus   = ($urandom_range(0, 5) == 0);
            capture    = $urandom_range(0, 1) == 1;
            save       = ($urandom_range(0, 4) == 0);
            restore    = ($urandom_range(0, 4) == 0);
            assert_bus = $urandom_range(0, 1) == 1;
            bus_in     = WIDTH'($urandom);
            alu        = 5'($urandom);
            cond_sel   = 3'($urandom);
            tick("rnd");
        end
        idle();
        tick("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
